prof_session_ctrl: RTL
======================

Name: prof_session_ctrl

Overview:
Sequences the cache profiler for one measurement session. Arms and clears the counters, opens the counting window on a start-PC match and closes it on a stop-PC match or command. It then waits for in-flight accesses to drain and streams every counter out over a valid/ready port to the MMIO/UART reader. It sits between the core's PC/commit stream, the profiler's enable/clear/select inputs, and the debug readout bus.

Parameters:
XLEN, 32, data/PC width
NUM_CNT, 15, number of profiler counters behind the select mux
CNT_W, 40, counter width (XLEN+8); upper bits beyond CNT_W read as zero
START_PC_DEF, 32'h80000088, start-PC register value after reset
STOP_PC_DEF, 32'h00000000, stop-PC register value after reset (0 = PC stop disabled)
DRAIN_MAX, 64, maximum DRAIN cycles before a forced close

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
pc_addr_i  in  XLEN  committed PC
pc_valid_i  in  1  pc_addr_i valid this cycle
cmd_valid_i  in  1  command strobe
cmd_i  in  3  0=ARM 1=STOP 2=ABORT 3=SET_START 4=SET_STOP, others ignored
cmd_data_i  in  XLEN  PC value for SET_START/SET_STOP
prof_idle_i  in  1  profiler has no access in flight
cnt_val_i  in  CNT_W  counter selected by cnt_sel_o (combinational in profiler)
prof_en_o  out  1  profiler counting enable
prof_clr_o  out  1  one-cycle counter clear pulse
cnt_sel_o  out  4  counter index
rd_valid_o  out  1  readout word valid
rd_data_o  out  XLEN  readout word
rd_ready_i  in  1  reader accepts word
run_cycles_o  out  XLEN  cycles spent in RUN, saturating
state_o  out  3  current FSM state encoding
drain_to_o  out  1  sticky: last DRAIN ended by timeout

Behaviour:
- Reset: state IDLE. All outputs 0. Start register = START_PC_DEF, stop register = STOP_PC_DEF.
- States: IDLE=0, ARMED=1, RUN=2, DRAIN=3, LOAD=4, SHOW=5, DONE=6.
- Commands have priority over PC matches in the same cycle. Only one command is processed per cycle.
- SET_START/SET_STOP: accepted only in IDLE or DONE; ignored elsewhere. They update the register and leave the state unchanged.
- ABORT from any state: next state IDLE; prof_en_o=0, rd_valid_o=0, idx/half cleared. Counters are not cleared.
- IDLE/DONE + ARM -> ARMED. prof_clr_o=1 for exactly that transition cycle. run_cycles_o and drain_to_o are cleared.
- ARMED -> RUN when pc_valid_i and pc_addr_i==start register. prof_en_o=1 from the next cycle. A stop match in the same cycle is ignored.
- ARMED + STOP -> IDLE, no dump.
- RUN:
  - run_cycles_o increments every cycle and saturates at all-ones.
  - Leaves to DRAIN on the STOP command, or on pc_valid_i with pc_addr_i==stop register when the stop register is nonzero.
- DRAIN:
  - prof_en_o stays 1 so in-flight latency keeps accumulating.
  - A drain counter starts at 0.
  - When prof_idle_i=1: prof_en_o<=0 and go to LOAD with idx=0, half=0.
  - When the counter reaches DRAIN_MAX-1 without prof_idle_i: same transition, and drain_to_o<=1.
- LOAD (exactly 1 cycle):
  - cnt_sel_o=idx.
  - rd_data_o <= half ? zero-extended cnt_val_i[CNT_W-1:XLEN] : cnt_val_i[XLEN-1:0].
  - rd_valid_o<=1, then go to SHOW.
- SHOW:
  - rd_valid_o and rd_data_o are held stable until rd_ready_i.
  - On handshake: rd_valid_o<=0, then:
    - if half=0: half<=1, go to LOAD;
    - otherwise, if idx==NUM_CNT-1: go to DONE;
    - otherwise: idx<=idx+1, half<=0, go to LOAD.
- Readout order: counter 0 lo, counter 0 hi, counter 1 lo, and so on; 2*NUM_CNT words in total. Each word takes a minimum of 2 cycles.
- DONE: counters remain frozen and readable. STOP is ignored. ARM starts a new session.
- prof_en_o is 0 in every state except RUN and DRAIN.
- pc_valid_i=0 suppresses all PC matching.
- rst_i mid-dump aborts immediately to the reset values; no partial word is held.

Test Plan:
- Reset, ARM, PC stream 0x80000000, 0x80000088 -> prof_clr_o one pulse; ARMED then RUN; prof_en_o rises the cycle after the 0x80000088 match.
- SET_STOP 0x800001F0; run 100 cycles; hit the stop PC with prof_idle_i=0 for 5 cycles -> DRAIN lasts 5 cycles, prof_en_o falls when idle, drain_to_o=0, run_cycles_o=100.
- prof_idle_i held 0 in DRAIN -> forced LOAD after 64 cycles; drain_to_o=1.
- Dump with cnt_val_i=40'hA5_1234_5678 for counter 3 and rd_ready_i always 1 -> words 6,7 = 0x12345678, 0x000000A5; 30 words total; DONE.
- rd_ready_i low for 10 cycles in SHOW -> rd_valid_o/rd_data_o stable; no index advance.
- ABORT during SHOW and rst_i during LOAD -> IDLE, rd_valid_o=0, prof_en_o=0; SET_START in RUN is ignored (start register unchanged).

Source files
------------

// File: rtl/prof_session_ctrl.sv
// Profiler session sequencer: arms/clears the counters, gates counting between
// start/stop PC matches, drains in-flight accesses and streams counters out.
module prof_session_ctrl #(
    parameter int              XLEN         = 32,
    parameter int              NUM_CNT      = 15,
    parameter int              CNT_W        = 40,
    parameter logic [XLEN-1:0] START_PC_DEF = 32'h80000088,
    parameter logic [XLEN-1:0] STOP_PC_DEF  = 32'h00000000,
    parameter int              DRAIN_MAX    = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [XLEN-1:0]  pc_addr_i,
    input  logic             pc_valid_i,
    input  logic             cmd_valid_i,
    input  logic [2:0]       cmd_i,
    input  logic [XLEN-1:0]  cmd_data_i,
    input  logic             prof_idle_i,
    input  logic [CNT_W-1:0] cnt_val_i,
    output logic             prof_en_o,
    output logic             prof_clr_o,
    output logic [3:0]       cnt_sel_o,
    output logic             rd_valid_o,
    output logic [XLEN-1:0]  rd_data_o,
    input  logic             rd_ready_i,
    output logic [XLEN-1:0]  run_cycles_o,
    output logic [2:0]       state_o,
    output logic             drain_to_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARMED = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_LOAD  = 3'd4;
    localparam logic [2:0] S_SHOW  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [2:0] CMD_ARM       = 3'd0;
    localparam logic [2:0] CMD_STOP      = 3'd1;
    localparam logic [2:0] CMD_ABORT     = 3'd2;
    localparam logic [2:0] CMD_SET_START = 3'd3;
    localparam logic [2:0] CMD_SET_STOP  = 3'd4;

    localparam int         DW       = $clog2(DRAIN_MAX);
    localparam logic [3:0] LAST_IDX = 4'(NUM_CNT - 1);

    logic [2:0]      state;
    logic [XLEN-1:0] start_pc;
    logic [XLEN-1:0] stop_pc;
    logic [3:0]      idx;
    logic            half;
    logic [DW-1:0]   drain_cnt;
    logic [XLEN-1:0] lo_word;
    logic [XLEN-1:0] hi_word;
    logic            stop_cmd;
    logic            stop_hit;

    assign lo_word  = cnt_val_i[XLEN-1:0];
    assign hi_word  = XLEN'(cnt_val_i >> XLEN);
    assign stop_cmd = cmd_valid_i && (cmd_i == CMD_STOP);
    // A zero stop register disables PC-based stopping.
    assign stop_hit = pc_valid_i && (stop_pc != '0) && (pc_addr_i == stop_pc);

    assign cnt_sel_o = idx;
    assign state_o   = state;

    // rd_valid_o/rd_data_o: a word is offered while rd_valid_o=1 and is held
    // unchanged until the cycle rd_ready_i=1 completes the handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= S_IDLE;
            start_pc     <= START_PC_DEF;
            stop_pc      <= STOP_PC_DEF;
            idx          <= '0;
            half         <= 1'b0;
            drain_cnt    <= '0;
            prof_en_o    <= 1'b0;
            prof_clr_o   <= 1'b0;
            rd_valid_o   <= 1'b0;
            rd_data_o    <= '0;
            run_cycles_o <= '0;
            drain_to_o   <= 1'b0;
        end else begin
            prof_clr_o <= 1'b0;
            if (cmd_valid_i && cmd_i == CMD_ABORT) begin
                state      <= S_IDLE;
                prof_en_o  <= 1'b0;
                rd_valid_o <= 1'b0;
                idx        <= '0;
                half       <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (cmd_valid_i) begin
                            case (cmd_i)
                                CMD_ARM: begin
                                    state        <= S_ARMED;
                                    prof_clr_o   <= 1'b1;
                                    run_cycles_o <= '0;
                                    drain_to_o   <= 1'b0;
                                end
                                CMD_SET_START: start_pc <= cmd_data_i;
                                CMD_SET_STOP:  stop_pc  <= cmd_data_i;
                                default: ;
                            endcase
                        end
                    end
                    S_ARMED: begin
                        if (stop_cmd) begin
                            state <= S_IDLE;
                        end else if (pc_valid_i && pc_addr_i == start_pc) begin
                            state     <= S_RUN;
                            prof_en_o <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (run_cycles_o != '1) run_cycles_o <= run_cycles_o + XLEN'(1);
                        if (stop_cmd || stop_hit) begin
                            state     <= S_DRAIN;
                            drain_cnt <= '0;
                        end
                    end
                    S_DRAIN: begin
                        if (prof_idle_i || drain_cnt == DW'(DRAIN_MAX - 1)) begin
                            state     <= S_LOAD;
                            prof_en_o <= 1'b0;
                            idx       <= '0;
                            half      <= 1'b0;
                            if (!prof_idle_i) drain_to_o <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt + DW'(1);
                        end
                    end
                    S_LOAD: begin
                        rd_data_o  <= half ? hi_word : lo_word;
                        rd_valid_o <= 1'b1;
                        state      <= S_SHOW;
                    end
                    S_SHOW: begin
                        if (rd_ready_i) begin
                            rd_valid_o <= 1'b0;
                            if (!half) begin
                                half  <= 1'b1;
                                state <= S_LOAD;
                            end else if (idx == LAST_IDX) begin
                                state <= S_DONE;
                            end else begin
                                idx   <= idx + 4'd1;
                                half  <= 1'b0;
                                state <= S_LOAD;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
